// File: rtl/life_grid_ctrl_pkg.sv
// Shared types for the life grid controller: grid geometry, grid word and controller states.
package life_grid_ctrl_pkg;

  localparam int GRID_ROWS  = 8;
  localparam int GRID_COLS  = 8;
  localparam int GRID_CELLS = GRID_ROWS * GRID_COLS;

  // Cell index is row*GRID_COLS + col.
  typedef logic [GRID_CELLS-1:0] grid_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/life_grid_ctrl_tick_div.sv
// Generation tick divider: counts while en is high, clears whenever en is low,
// and pulses tc on the last of every STEP_DIV enabled cycles.
module life_tick_div #(
  parameter int STEP_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/life_grid_ctrl.sv
// Generation register controller: row-wise seed load, single-step and divided free-run,
// with a saturating generation counter and stable/extinct flags.
module life_grid_ctrl
  import life_grid_ctrl_pkg::*;
#(
  parameter int STEP_DIV       = 16,
  parameter int GEN_W          = 16,
  parameter bit HALT_ON_STABLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [7:0]       load_data,
  input  logic             run,
  input  logic             step,
  input  logic [63:0]      grid_evolve,
  output logic [63:0]      grid,
  output logic [GEN_W-1:0] gen_count,
  output logic             stable,
  output logic             extinct,
  output logic             halted,
  output logic             busy
);

  localparam logic [2:0] LAST_ROW = 3'(GRID_ROWS - 1);

  ctrl_state_t state, state_nxt;
  logic [2:0]  row_ptr;
  logic        run_hold;   // set by an auto-halt, released only once run goes low
  logic        tick;
  logic        div_en;
  logic        do_load, do_update, load_done, set_halt, clr_halt;

  assign stable  = (grid_evolve == grid);
  assign extinct = (grid == '0);
  assign busy    = (state != IDLE);
  assign div_en  = (state == RUN) && run;

  life_tick_div #(
    .STEP_DIV(STEP_DIV)
  ) u_tick_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (div_en),
    .tc   (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake: a seed beat transfers on a clock edge where load_valid && load_ready;
  // load_ready depends only on state, never on load_valid.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    do_load    = 1'b0;
    do_update  = 1'b0;
    load_done  = 1'b0;
    set_halt   = 1'b0;
    clr_halt   = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          do_load   = 1'b1;
          state_nxt = LOAD;
        end else if (run && !run_hold) begin
          state_nxt = RUN;
        end else if (step) begin
          do_update = 1'b1;
          clr_halt  = 1'b1;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          do_load = 1'b1;
          if (row_ptr == LAST_ROW) begin
            load_done = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      RUN: begin
        if (!run) begin
          state_nxt = IDLE;
        end else if (tick) begin
          do_update = 1'b1;
          if (HALT_ON_STABLE && stable) begin
            set_halt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grid      <= '0;
      gen_count <= '0;
      halted    <= 1'b0;
      row_ptr   <= '0;
      run_hold  <= 1'b0;
    end else begin
      // row_ptr wraps back to 0 after the last row
      if (do_load) begin
        grid[{row_ptr, 3'b000} +: GRID_COLS] <= load_data;
        row_ptr                              <= row_ptr + 1'b1;
      end
      if (do_update) begin
        grid <= grid_evolve;
        if (gen_count != {GEN_W{1'b1}}) begin
          gen_count <= gen_count + 1'b1;
        end
      end
      if (load_done) begin
        gen_count <= '0;
      end
      if (set_halt) begin
        halted <= 1'b1;
      end else if (clr_halt || load_done) begin
        halted <= 1'b0;
      end
      if (set_halt) begin
        run_hold <= 1'b1;
      end else if (!run) begin
        run_hold <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_life_grid_ctrl.sv
// Bench for life_grid_ctrl: Game of Life datapath model, directed scenarios plus random
// stimulus, cycle-by-cycle scoreboard against a behavioural reference model.
module tb_life_grid_ctrl;
  import life_grid_ctrl_pkg::*;

  localparam int STEP_DIV = 4;
  localparam int GEN_W    = 16;
  localparam bit HALT     = 1'b1;
  localparam int GMAX     = (1 << GEN_W) - 1;
  localparam int W        = 64 + GEN_W + 5;

  // ---------------- clock / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, load_valid, run, step;
  logic [7:0]       load_data;
  logic             load_ready, stable, extinct, halted, busy;
  logic [63:0]      grid, grid_evolve;
  logic [GEN_W-1:0] gen_count;

  logic             s_step, s_load_ready, s_stable, s_extinct, s_halted, s_busy;
  logic [63:0]      s_grid, s_grid_evolve;
  logic [1:0]       s_gen;

  int checks   = 0;
  int failures = 0;

  // Conway rules on a bounded 8x8 field (cells outside the grid are dead).
  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] n;
    int          cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                (c + dc) >= 0 && (c + dc) < 8) begin
              cnt += int'(g[(r + dr) * 8 + c + dc]);
            end
          end
        end
        n[r * 8 + c] = (cnt == 3) || (g[r * 8 + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  assign grid_evolve   = life_next(grid);
  assign s_grid_evolve = life_next(s_grid);

  life_grid_ctrl #(
    .STEP_DIV(STEP_DIV), .GEN_W(GEN_W), .HALT_ON_STABLE(HALT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .run(run), .step(step), .grid_evolve(grid_evolve),
    .grid(grid), .gen_count(gen_count), .stable(stable), .extinct(extinct),
    .halted(halted), .busy(busy)
  );

  life_grid_ctrl #(
    .STEP_DIV(1), .GEN_W(2), .HALT_ON_STABLE(1'b1)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .load_valid(1'b0), .load_ready(s_load_ready),
    .load_data(8'h00), .run(1'b0), .step(s_step), .grid_evolve(s_grid_evolve),
    .grid(s_grid), .gen_count(s_gen), .stable(s_stable), .extinct(s_extinct),
    .halted(s_halted), .busy(s_busy)
  );

  // ---------------- reference model ----------------
  logic [7:0]   m_rows[8];
  bit           m_loading, m_running, m_need_low, m_halted;
  int           m_ptr, m_age, m_gen;
  logic [W-1:0] pending;
  logic [W-1:0] exp_q[$];

  function automatic logic [63:0] m_grid();
    logic [63:0] g;
    for (int r = 0; r < 8; r++) g[r * 8 +: 8] = m_rows[r];
    return g;
  endfunction

  task automatic m_advance(input logic [63:0] nxt);
    for (int r = 0; r < 8; r++) m_rows[r] = nxt[r * 8 +: 8];
    if (m_gen < GMAX) m_gen++;
  endtask

  task automatic model_clock(input bit r, input bit lv, input logic [7:0] ld,
                             input bit rn, input bit st);
    logic [63:0] cur, nxt, g;
    if (!r) begin
      for (int i = 0; i < 8; i++) m_rows[i] = 8'h00;
      m_loading = 0; m_running = 0; m_need_low = 0; m_halted = 0;
      m_ptr = 0; m_age = 0; m_gen = 0;
    end else begin
      cur = m_grid();
      nxt = life_next(cur);
      if (m_loading) begin
        if (lv) begin
          m_rows[m_ptr] = ld;
          if (m_ptr == 7) begin
            m_loading = 0; m_ptr = 0; m_gen = 0; m_halted = 0;
          end else begin
            m_ptr++;
          end
        end
      end else if (m_running) begin
        if (!rn) begin
          m_running = 0;
        end else begin
          m_age++;
          if (m_age % STEP_DIV == 0) begin
            m_advance(nxt);
            if (HALT && nxt == cur) begin
              m_halted = 1; m_running = 0; m_need_low = 1;
            end
          end
        end
      end else begin
        if (lv) begin
          m_rows[0] = ld; m_ptr = 1; m_loading = 1;
        end else if (rn && !m_need_low) begin
          m_running = 1; m_age = 0;
        end else if (st) begin
          m_advance(nxt);
          m_halted = 0;
        end
      end
      if (!rn) m_need_low = 0;
    end
    g = m_grid();
    pending = {g, GEN_W'(m_gen), !m_running, (m_loading || m_running), m_halted,
               (life_next(g) == g), (g == 64'h0)};
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit r, input bit lv, input logic [7:0] ld,
                     input bit rn, input bit st);
    rst_n = r; load_valid = lv; load_data = ld; run = rn; step = st;
    model_clock(r, lv, ld, rn, st);
    @(posedge clk);
    exp_q.push_back(pending);
    #1;
  endtask

  task automatic load_seed(input logic [7:0] rows[8], input int gap_after);
    for (int r = 0; r < 8; r++) begin
      cyc(1, 1, rows[r], 0, 0);
      if (r == gap_after) begin
        for (int g = 0; g < 3; g++) cyc(1, 0, 8'($urandom), 1'($urandom_range(0, 1)), 0);
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grid", grid, e[W-1 -: 64]);
        chk("gen_count", 64'(gen_count), 64'(e[GEN_W+4:5]));
        chk("flags_lr_busy_halt_stab_ext", 64'({load_ready, busy, halted, stable, extinct}),
            64'(e[4:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] blink[8];
    logic [7:0] block[8];
    bit         rn;
    blink = '{8'h00, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00};
    block = '{8'h00, 8'h00, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00};
    s_step = 1'b0;

    // reset with toggling inputs
    for (int i = 0; i < 2; i++)
      cyc(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    chk("reset_grid", grid, 64'h0);
    chk("reset_state", 64'({gen_count, load_ready, busy, halted}), 64'({16'h0, 3'b100}));

    // blinker load with a gap after row 2
    load_seed(blink, 2);
    chk("blinker_load", grid, 64'h0000_0000_1C00_0000);
    chk("blinker_load_idle", 64'({busy, gen_count}), 64'h0);

    // single steps
    cyc(1, 0, 0, 0, 1);
    chk("step1_grid", grid, 64'h0000_0008_0808_0000);
    chk("step1_gen", 64'(gen_count), 64'd1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    chk("step2_grid", grid, 64'h0000_0000_1C00_0000);
    chk("step2_gen", 64'(gen_count), 64'd2);

    // free run for 17 clocks, then an aborted run just before its tick
    load_seed(blink, -1);
    for (int i = 0; i < 17; i++) cyc(1, 0, 0, 1, 0);
    chk("run17_gen", 64'(gen_count), 64'd4);
    chk("run17_grid", grid, 64'h0000_0000_1C00_0000);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    chk("run_abort_gen", 64'(gen_count), 64'd4);
    chk("run_abort_idle", 64'(busy), 64'd0);

    // block still life halts RUN at the first tick and stays halted while run is held
    load_seed(block, -1);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, 0);
    chk("block_grid", grid, 64'h0000_0018_1800_0000);
    chk("block_halt", 64'({gen_count, halted, busy}), 64'({16'd1, 2'b10}));
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    chk("step_clears_halt", 64'({gen_count, halted}), 64'({16'd2, 1'b0}));

    // load beat wins over run and step; reset discards a partial seed
    cyc(1, 1, 8'hFF, 1, 1);
    chk("priority_load", 64'({busy, gen_count}), 64'({1'b1, 16'd2}));
    chk("priority_row0", 64'(grid[7:0]), 64'hFF);
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'h55, 1, 1);
    cyc(0, 1, 8'hAA, 1, 1);
    chk("reset_midload", grid, 64'h0);
    chk("reset_midload_idle", 64'({busy, load_ready}), 64'({2'b01}));

    // saturation of a 2-bit counter
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      s_step = 1'b1;
      cyc(1, 0, 0, 0, 0);
      s_step = 1'b0;
      chk("sat_gen", 64'(s_gen), 64'((i + 1 > 3) ? 3 : i + 1));
      cyc(1, 0, 0, 0, 0);
    end

    // random traffic
    rn = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) rn = !rn;
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0), 8'($urandom),
          rn, ($urandom_range(0, 6) == 0));
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) chk("scoreboard_drain", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
